// File: rtl/alu_exec_sequencer.sv
// Multicycle execute sequencer: reads two operands from the register file, holds them on
// the ALU, captures the result and flags, updates NZCV and writes the result back.
module alu_exec_sequencer #(
  parameter int WIDTH = 32,
  parameter int RADDR = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [RADDR-1:0] rs1,
  input  logic [RADDR-1:0] rs2,
  input  logic [RADDR-1:0] rd,
  input  logic             flag_we,
  output logic             busy,
  output logic             done,
  output logic [RADDR-1:0] rf_raddr,
  input  logic [WIDTH-1:0] rf_rdata,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_gout,
  input  logic             alu_n,
  input  logic             alu_z,
  input  logic             alu_c,
  input  logic             alu_v,
  output logic             rf_we,
  output logic [RADDR-1:0] rf_waddr,
  output logic [WIDTH-1:0] rf_wdata,
  output logic [3:0]       nzcv,
  output logic [2:0]       dbg_state_o
);

  // Handshake: start is sampled only in IDLE; busy covers RD_A..WB; done pulses for one cycle in WB.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_A = 3'd1,
    S_RD_B = 3'd2,
    S_EXEC = 3'd3,
    S_WB   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [RADDR-1:0]   raddr_q, raddr_d;
  logic [RADDR-1:0]   rs2_q, rs2_d;
  logic [RADDR-1:0]   rd_q, rd_d;
  logic               fwe_q, fwe_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2:0]         sel_q, sel_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [3:0]         nzcv_q, nzcv_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      raddr_q  <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      fwe_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      sel_q    <= '0;
      result_q <= '0;
      nzcv_q   <= '0;
    end else begin
      state_q  <= state_d;
      raddr_q  <= raddr_d;
      rs2_q    <= rs2_d;
      rd_q     <= rd_d;
      fwe_q    <= fwe_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sel_q    <= sel_d;
      result_q <= result_d;
      nzcv_q   <= nzcv_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    raddr_d  = raddr_q;
    rs2_d    = rs2_q;
    rd_d     = rd_q;
    fwe_d    = fwe_q;
    a_d      = a_q;
    b_d      = b_q;
    sel_d    = sel_q;
    result_d = result_q;
    nzcv_d   = nzcv_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sel_d   = op;
          rs2_d   = rs2;
          rd_d    = rd;
          fwe_d   = flag_we;
          raddr_d = rs1;
          state_d = S_RD_A;
        end
      end
      S_RD_A: begin
        a_d     = rf_rdata;
        raddr_d = rs2_q;
        state_d = S_RD_B;
      end
      S_RD_B: begin
        b_d     = rf_rdata;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        result_d = alu_gout;
        // Logic/pass-B ops leave carry and overflow untouched.
        if (fwe_q) begin
          if (!sel_q[2]) nzcv_d = {alu_n, alu_z, alu_c, alu_v};
          else           nzcv_d = {alu_n, alu_z, nzcv_q[1:0]};
        end
        state_d = S_WB;
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_WB);
  assign rf_we       = (state_q == S_WB) && (rd_q != '0);
  assign rf_raddr    = raddr_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_sel     = sel_q;
  assign rf_waddr    = rd_q;
  assign rf_wdata    = result_q;
  assign nzcv        = nzcv_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// Directed bench for alu_exec_sequencer with a register-file model and a constant-driven ALU model.
module tb_alu_exec_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [3:0]  rs1, rs2, rd;
  logic        flag_we;
  logic        busy, done;
  logic [3:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_sel;
  logic [31:0] alu_gout;
  logic        alu_n, alu_z, alu_c, alu_v;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [3:0]  nzcv;
  logic [2:0]  dbg_state;

  logic [31:0] rf [16];
  int          checks;
  int          errors;
  int          we_count;

  alu_exec_sequencer #(.WIDTH(32), .RADDR(4)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs1(rs1), .rs2(rs2), .rd(rd), .flag_we(flag_we),
    .busy(busy), .done(done), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_gout(alu_gout),
    .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .nzcv(nzcv), .dbg_state_o(dbg_state)
  );

  assign rf_rdata = rf[rf_raddr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; the register-file write presented during the cycle lands at the edge.
  task automatic tick();
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    we = rf_we;
    wa = rf_waddr;
    wd = rf_wdata;
    @(posedge clk);
    #1;
    if (we) begin
      rf[wa] = wd;
      we_count++;
    end
  endtask

  task automatic set_alu(input logic [31:0] g, input logic [3:0] f);
    alu_gout = g;
    {alu_n, alu_z, alu_c, alu_v} = f;
  endtask

  task automatic run_op(input logic [2:0] o, input logic [3:0] s1, input logic [3:0] s2,
                        input logic [3:0] d, input logic fwe, input logic [31:0] exp_a,
                        input logic [31:0] exp_b, input logic [31:0] exp_res,
                        input logic exp_we, input logic [3:0] exp_nzcv);
    int wc;
    op = o; rs1 = s1; rs2 = s2; rd = d; flag_we = fwe; start = 1'b1;
    tick();
    start = 1'b0;
    check("rda_state", 32'(dbg_state), 32'd1);
    check("rda_busy", 32'(busy), 32'd1);
    check("rda_raddr", 32'(rf_raddr), 32'(s1));
    check("rda_done", 32'(done), 32'd0);
    tick();
    check("rdb_alu_a", alu_a, exp_a);
    check("rdb_raddr", 32'(rf_raddr), 32'(s2));
    tick();
    check("exec_alu_b", alu_b, exp_b);
    check("exec_alu_sel", 32'(alu_sel), 32'(o));
    tick();
    check("wb_done", 32'(done), 32'd1);
    check("wb_we", 32'(rf_we), 32'(exp_we));
    check("wb_waddr", 32'(rf_waddr), 32'(d));
    check("wb_wdata", rf_wdata, exp_res);
    check("wb_nzcv", 32'(nzcv), 32'(exp_nzcv));
    wc = we_count;
    tick();
    check("idle_done", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_we", 32'(rf_we), 32'd0);
    check("write_count", 32'(we_count - wc), 32'(exp_we));
  endtask

  initial begin
    int wc;
    checks = 0; errors = 0; we_count = 0;
    for (int i = 0; i < 16; i++) rf[i] = 32'h0;
    rf[1] = 32'd5;
    rf[2] = 32'd7;
    rf[4] = 32'hFFFF_FFFF;
    reset = 1'b1; start = 1'b0; op = 3'd0; rs1 = 4'd0; rs2 = 4'd0; rd = 4'd0; flag_we = 1'b0;
    set_alu(32'h0, 4'h0);
    tick();
    tick();
    reset = 1'b0;
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_we", 32'(rf_we), 32'd0);
    check("rst_raddr", 32'(rf_raddr), 32'd0);
    check("rst_waddr", 32'(rf_waddr), 32'd0);
    check("rst_wdata", rf_wdata, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_alu_sel", 32'(alu_sel), 32'd0);
    check("rst_nzcv", 32'(nzcv), 32'd0);

    // Basic add: r3 = r1 + r2 = 12.
    set_alu(32'd12, 4'b0000);
    run_op(3'b000, 4'd1, 4'd2, 4'd3, 1'b1, 32'd5, 32'd7, 32'd12, 1'b1, 4'b0000);
    check("r3_value", rf[3], 32'd12);

    // Arith op writes all flags; logic op keeps C,V.
    set_alu(32'h0, 4'b0110);
    run_op(3'b001, 4'd1, 4'd2, 4'd6, 1'b1, 32'd5, 32'd7, 32'h0, 1'b1, 4'b0110);
    set_alu(32'h8000_0000, 4'b1001);
    run_op(3'b100, 4'd2, 4'd1, 4'd6, 1'b1, 32'd7, 32'd5, 32'h8000_0000, 1'b1, 4'b1010);
    check("r6_value", rf[6], 32'h8000_0000);

    // r0 destination with flag_we=0: done pulses, no write, flags held.
    set_alu(32'h1234_5678, 4'b1111);
    run_op(3'b010, 4'd1, 4'd2, 4'd0, 1'b0, 32'd5, 32'd7, 32'h1234_5678, 1'b0, 4'b1010);
    check("r0_value", rf[0], 32'h0);

    // start held for 12 cycles: accepts every 5 cycles, done on the 4th of each.
    set_alu(32'h0000_00AA, 4'b0101);
    op = 3'b011; rs1 = 4'd1; rs2 = 4'd2; rd = 4'd5; flag_we = 1'b0; start = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check($sformatf("burst_busy_%0d", k), 32'(busy), 32'((k % 5) != 0));
      check($sformatf("burst_done_%0d", k), 32'(done), 32'((k % 5) == 4));
    end
    start = 1'b0;
    tick();
    tick();
    check("burst_last_done", 32'(done), 32'd1);
    tick();
    check("burst_idle", 32'(dbg_state), 32'd0);
    check("burst_writes", 32'(we_count), 32'd6);
    check("burst_nzcv", 32'(nzcv), 32'b1010);

    // Same register for both sources and destination.
    set_alu(32'hFFFF_FFFF, 4'b0000);
    run_op(3'b110, 4'd4, 4'd4, 4'd4, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           1'b1, 4'b1010);
    check("r4_value", rf[4], 32'hFFFF_FFFF);

    // Reset asserted for two cycles while in EXEC aborts the op.
    set_alu(32'hDEAD_BEEF, 4'b1111);
    op = 3'b000; rs1 = 4'd1; rs2 = 4'd2; rd = 4'd7; flag_we = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("abort_in_exec", 32'(dbg_state), 32'd3);
    wc = we_count;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("abort_state", 32'(dbg_state), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_we", 32'(rf_we), 32'd0);
    check("abort_nzcv", 32'(nzcv), 32'd0);
    check("abort_alu_a", alu_a, 32'd0);
    check("abort_alu_sel", 32'(alu_sel), 32'd0);
    check("abort_wdata", rf_wdata, 32'd0);
    tick();
    tick();
    check("abort_no_write", 32'(we_count - wc), 32'd0);
    check("abort_r7", rf[7], 32'h0);
    check("abort_still_idle", 32'(dbg_state), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
